// File: rtl/seg7_scan_reader.sv
// Monitors a multiplexed active-low 7-segment bus and recovers the BCD value
// shown on each digit position, with a stability filter and frame tracking.
module seg7_scan_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [6:0]                seg,
    input  logic [NUM_DIGITS-1:0]     an,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      pattern_err,
    output logic                      anode_err,
    output logic                      frame_done
);

    typedef enum logic [1:0] {WAIT, SETTLE, HOLD} state_t;

    localparam int SW = NUM_DIGITS + 7;
    localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] FULL_CNT = 8'(STABLE_CYCLES);

    // Returns {recognised, value}; anything off-table (including blank) is unrecognised.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b0000001: decode = {1'b1, 4'd0};
            7'b1001111: decode = {1'b1, 4'd1};
            7'b0010010: decode = {1'b1, 4'd2};
            7'b0000110: decode = {1'b1, 4'd3};
            7'b1001100: decode = {1'b1, 4'd4};
            7'b0100100: decode = {1'b1, 4'd5};
            7'b0100000: decode = {1'b1, 4'd6};
            7'b0001111: decode = {1'b1, 4'd7};
            7'b0000000: decode = {1'b1, 4'd8};
            7'b0001100: decode = {1'b1, 4'd9};
            default:    decode = {1'b0, 4'd0};
        endcase
    endfunction

    state_t                    state, state_n;
    logic [SW-1:0]             s, s_n;
    logic [7:0]                cnt, cnt_n;
    logic [NUM_DIGITS-1:0]     seen, seen_n;
    logic [4*NUM_DIGITS-1:0]   digits_n;
    logic [NUM_DIGITS-1:0]     valid_n;
    logic                      perr_n, aerr_n, fdone_n;
    logic [SW-1:0]             in_cat;
    logic [3:0]                nlow;
    logic [4:0]                dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= WAIT;
            s           <= '1;
            cnt         <= '0;
            seen        <= '0;
            digits      <= '0;
            digit_valid <= '0;
            pattern_err <= 1'b0;
            anode_err   <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_n;
            s           <= s_n;
            cnt         <= cnt_n;
            seen        <= seen_n;
            digits      <= digits_n;
            digit_valid <= valid_n;
            pattern_err <= perr_n;
            anode_err   <= aerr_n;
            frame_done  <= fdone_n;
        end
    end

    always_comb begin
        state_n  = state;
        s_n      = s;
        cnt_n    = cnt;
        seen_n   = seen;
        digits_n = digits;
        valid_n  = digit_valid;
        perr_n   = 1'b0;
        aerr_n   = 1'b0;
        fdone_n  = 1'b0;
        in_cat   = {an, seg};
        dec      = decode(seg);
        nlow     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nlow = nlow + {3'b000, ~an[i]};
        end

        if (in_cat != s) begin
            s_n     = in_cat;
            cnt_n   = '0;
            state_n = (nlow == 4'd1) ? SETTLE : WAIT;
        end else begin
            case (state)
                WAIT: begin
                    // Counter saturates at FULL_CNT so anode_err fires only once per stable run.
                    if (cnt < FULL_CNT) begin
                        cnt_n = cnt + 8'd1;
                        if (cnt == LAST_CNT && nlow > 4'd1) begin
                            aerr_n = 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    cnt_n = cnt + 8'd1;
                    if (cnt == LAST_CNT) begin
                        state_n = HOLD;
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (!an[i]) begin
                                if (dec[4]) begin
                                    digits_n[4*i +: 4] = dec[3:0];
                                end
                                valid_n[i] = dec[4];
                                seen_n[i]  = 1'b1;
                            end
                        end
                        perr_n = ~dec[4];
                        // Completing the frame clears seen, including the bit just set.
                        if (seen_n == '1) begin
                            fdone_n = 1'b1;
                            seen_n  = '0;
                        end
                    end
                end
                HOLD: begin
                    cnt_n = cnt;
                end
                default: begin
                    state_n = WAIT;
                end
            endcase
        end
    end

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Inverse of the board's BCD-to-7-segment digit driver: watches a multiplexed, active-low 7-segment bus (segment lines plus anode selects) and recovers the BCD value shown on each digit position.
- Used for loop-back self-check of the display path and as a bench/monitor block next to the display driver.
- Sequential: per-sample stability filter, capture FSM, per-digit value registers, frame-completion tracking.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (anode lines), 1..8
- STABLE_CYCLES, 4, consecutive clocks {an,seg} must hold before capture, 1..255

Ports:
- clk  input  1  system clock; the only clock
- reset  input  1  synchronous, active-high reset
- seg  input  7  segment lines, active low, bit6..bit0 = a,b,c,d,e,f,g
- an  input  NUM_DIGITS  anode selects, active low, bit i = digit i
- digits  output  4*NUM_DIGITS  recovered BCD; digits[4i+3:4i] = digit i
- digit_valid  output  NUM_DIGITS  bit i = 1 when last capture for digit i decoded to 0..9
- pattern_err  output  1  one-cycle pulse: capture saw an unrecognised seg pattern
- anode_err  output  1  one-cycle pulse: stable an with more than one bit low
- frame_done  output  1  one-cycle pulse: every digit captured at least once since last pulse/reset

Behaviour:
- Clock and reset: single clock clk; reset synchronous, active-high, sampled only on rising clk edge.
- Reset values: digits=0, digit_valid=0, pattern_err=0, anode_err=0, frame_done=0, seen mask=0, sample reg s={all-ones an, 7'b1111111}, cnt=0, state=WAIT.
- Inputs share the clk domain; no synchroniser inside.
- Decode table (seg -> value), exact match only:
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4
  - 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0001100->9
  - Any other pattern, including all-ones blank, is unrecognised.
- Each edge, if {an,seg} != s: s<={an,seg}, cnt<=0, state<=SETTLE if an has exactly one bit low, else WAIT.
- FSM states:
  - WAIT: an all-high or multi-low. Hold until input changes. No capture. If an is multi-low, anode_err pulses once, on the edge the input has been stable for STABLE_CYCLES edges since entry.
  - SETTLE: input unchanged -> cnt<=cnt+1. When cnt==STABLE_CYCLES-1 and input unchanged, capture on that edge and go to HOLD.
  - HOLD: no further capture until input changes; a change returns to SETTLE/WAIT per the rule above.
- Latency: input first differs at edge k and then holds; outputs update at edge k+STABLE_CYCLES.
- Capture for selected digit i:
  - Recognised pattern: digits nibble i <= value, digit_valid[i]<=1.
  - Unrecognised pattern: nibble i unchanged, digit_valid[i]<=0, pattern_err pulses.
  - Either way, seen[i]<=1.
- frame_done: on the edge where the seen mask becomes all ones, pulse frame_done and clear seen to 0 on that same edge. The capturing digit's bit is not retained.
- Simultaneous events: a change on the capture edge is not possible (capture requires an unchanged input). A capture and frame_done on the same edge are allowed.
- Re-capture of the same digit before the frame completes overwrites the value; seen is unaffected.
- cnt saturates in HOLD (does not wrap).
- Reset mid-SETTLE discards the partial count. Any stable pattern present at release is re-captured STABLE_CYCLES edges after it first differs from the reset s value.
- The glitch filter is implicit: any input change shorter than STABLE_CYCLES edges never captures.

Test Plan:
- Reset, then an=1110, seg=0010010 held 6 cycles (STABLE_CYCLES=4) -> digits[3:0]=2 and digit_valid=0001 exactly 4 edges after the input change; no err pulses.
- Scan an=1110/1101/1011/0111 with seg patterns for 1,9,0,7, each held 8 cycles -> digits=16'h7091, digit_valid=1111, single frame_done pulse on the 4th capture, seen cleared.
- an=1101, seg=0010010 held 3 cycles then changed to 0100100 held 5 -> only 5 captured in nibble 1; 2 never appears.
- an=1110, seg=1111110 held 5 cycles -> pattern_err one pulse, digit_valid[0]=0, nibble 0 keeps its prior value.
- an=1100 held 6 cycles with valid seg -> anode_err one pulse, digits/digit_valid unchanged; an=1111 held -> no pulses.
- Assert reset for 1 cycle in mid-SETTLE of a new 4 on digit 2 -> all outputs zero after reset. With inputs still held, digit 2 = 4 appears 4 edges after the first post-reset edge.
